// File: rtl/lsu_dmem_if_pkg.sv
// Shared definitions for the load/store unit data-memory interface.
// Holds the cache status encoding, RV32 load/store funct3 codes, the LSU
// state encoding and two decode helpers used at request acceptance.
package lsu_dmem_if_pkg;

    // Cache status value meaning "access completes this cycle".
    localparam logic STATE_SUCCESS = 1'b1;

    // RV32 funct3 width/sign codes for loads and stores.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_RD   = 2'd1,
        LSU_WR   = 2'd2,
        LSU_RESP = 2'd3
    } lsu_state_e;

    // Loads accept B/H/W/BU/HU; stores accept only B/H/W.
    function automatic logic f3_illegal(input logic rnw, input logic [2:0] f3);
        if (rnw) begin
            return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        end
        return f3[2] || (f3 == 3'b011);
    endfunction

    // Natural alignment check; only meaningful for legal funct3 values.
    function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b01:   return lo[0];
            2'b10:   return lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane alignment for the LSU.
// Ports:
//   funct3      - RV32 width/sign code of the access
//   addr_lo     - byte offset within the word
//   rdata       - full word read from the cache
//   wdata       - LSB-aligned store data from the pipeline
//   load_data   - extracted and sign/zero-extended load result
//   merged_data - cache word with the addressed byte/half replaced by wdata
module lsu_align
    import lsu_dmem_if_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged_data
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [31:0] byte_mask;
    logic [31:0] half_mask;
    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;

    always_comb begin
        byte_sh   = {addr_lo, 3'b000};
        half_sh   = {addr_lo[1], 4'b0000};
        byte_val  = rdata[byte_sh +: 8];
        half_val  = rdata[half_sh +: 16];
        byte_mask = 32'h0000_00FF << byte_sh;
        half_mask = 32'h0000_FFFF << half_sh;

        case (funct3)
            F3_B:    load_data = {{24{byte_val[7]}}, byte_val};
            F3_BU:   load_data = {24'd0, byte_val};
            F3_H:    load_data = {{16{half_val[15]}}, half_val};
            F3_HU:   load_data = {16'd0, half_val};
            default: load_data = rdata;
        endcase

        case (funct3)
            F3_B:    merged_data = (rdata & ~byte_mask) | ({24'd0, wdata[7:0]} << byte_sh);
            F3_H:    merged_data = (rdata & ~half_mask) | ({16'd0, wdata[15:0]} << half_sh);
            default: merged_data = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_dmem_if.sv
// Load/store unit front end to a word-only data cache.
// Accepts one request at a time, decodes RV32 width/sign, performs
// read-modify-write for SB/SH, retries non-success cache cycles up to
// RETRY_MAX times and returns an extended load result with error flags.
// Ports:
//   i_clk, i_reset            - clock, async active-low reset
//   i_req_*/o_req_ready       - pipeline request handshake and payload
//   o_resp_*/i_resp_ready     - response handshake, data and error cause
//   o_enable/o_rnw/o_addr/o_wdata, i_rdata/i_status - cache port
module lsu_dmem_if
    import lsu_dmem_if_pkg::*;
#(
    parameter int AWIDTH    = 32,
    parameter int DWIDTH    = 32,
    parameter int RETRY_MAX = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_rnw,
    input  logic [2:0]        i_req_funct3,
    input  logic [AWIDTH-1:0] i_req_addr,
    input  logic [DWIDTH-1:0] i_req_wdata,
    output logic              o_resp_valid,
    input  logic              i_resp_ready,
    output logic [DWIDTH-1:0] o_resp_rdata,
    output logic              o_resp_err,
    output logic              o_resp_misaligned,
    output logic              o_enable,
    output logic              o_rnw,
    output logic [AWIDTH-1:0] o_addr,
    output logic [DWIDTH-1:0] o_wdata,
    input  logic [DWIDTH-1:0] i_rdata,
    input  logic              i_status
);

    localparam int RW = $clog2(RETRY_MAX + 1);

    lsu_state_e        state_q, state_d;
    logic              rnw_q, rnw_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0] store_data_q, store_data_d;
    logic [RW-1:0]     retry_q, retry_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DWIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic              resp_mis_q, resp_mis_d;
    logic              enable_q, enable_d;
    logic              cache_rnw_q, cache_rnw_d;
    logic [DWIDTH-1:0] cache_wdata_q, cache_wdata_d;

    logic [DWIDTH-1:0] load_data;
    logic [DWIDTH-1:0] merged_data;
    logic              retry_exhausted;

    lsu_align u_align (
        .funct3      (funct3_q),
        .addr_lo     (addr_q[1:0]),
        .rdata       (i_rdata),
        .wdata       (store_data_q),
        .load_data   (load_data),
        .merged_data (merged_data)
    );

    // The current non-success cycle is the RETRY_MAX-th consecutive one.
    assign retry_exhausted = (retry_q == RW'(RETRY_MAX - 1));

    always_comb begin
        state_d       = state_q;
        rnw_d         = rnw_q;
        funct3_d      = funct3_q;
        addr_d        = addr_q;
        store_data_d  = store_data_q;
        retry_d       = retry_q;
        req_ready_d   = req_ready_q;
        resp_valid_d  = resp_valid_q;
        resp_rdata_d  = resp_rdata_q;
        resp_err_d    = resp_err_q;
        resp_mis_d    = resp_mis_q;
        enable_d      = enable_q;
        cache_rnw_d   = cache_rnw_q;
        cache_wdata_d = cache_wdata_q;

        case (state_q)
            LSU_IDLE: begin
                if (i_req_valid) begin
                    rnw_d        = i_req_rnw;
                    funct3_d     = i_req_funct3;
                    addr_d       = i_req_addr;
                    store_data_d = i_req_wdata;
                    retry_d      = '0;
                    resp_rdata_d = '0;
                    req_ready_d  = 1'b0;
                    if (f3_illegal(i_req_rnw, i_req_funct3)) begin
                        state_d      = LSU_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_mis_d   = 1'b0;
                    end else if (addr_misaligned(i_req_funct3, i_req_addr[1:0])) begin
                        state_d      = LSU_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_mis_d   = 1'b1;
                    end else if (i_req_rnw || (i_req_funct3[1:0] != 2'b10)) begin
                        // Loads and sub-word stores both start with a read.
                        state_d     = LSU_RD;
                        enable_d    = 1'b1;
                        cache_rnw_d = 1'b1;
                    end else begin
                        state_d       = LSU_WR;
                        enable_d      = 1'b1;
                        cache_rnw_d   = 1'b0;
                        cache_wdata_d = i_req_wdata;
                    end
                end
            end

            LSU_RD, LSU_WR: begin
                if (i_status == STATE_SUCCESS) begin
                    retry_d = '0;
                    if ((state_q == LSU_RD) && !rnw_q) begin
                        state_d       = LSU_WR;
                        cache_rnw_d   = 1'b0;
                        cache_wdata_d = merged_data;
                    end else begin
                        state_d      = LSU_RESP;
                        enable_d     = 1'b0;
                        cache_rnw_d  = 1'b1;
                        resp_valid_d = 1'b1;
                        if (state_q == LSU_RD) begin
                            resp_rdata_d = load_data;
                        end
                    end
                end else if (retry_exhausted) begin
                    retry_d      = '0;
                    state_d      = LSU_RESP;
                    enable_d     = 1'b0;
                    cache_rnw_d  = 1'b1;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_mis_d   = 1'b0;
                end else begin
                    retry_d = retry_q + 1'b1;
                end
            end

            LSU_RESP: begin
                if (i_resp_ready) begin
                    state_d      = LSU_IDLE;
                    req_ready_d  = 1'b1;
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    resp_mis_d   = 1'b0;
                    resp_rdata_d = '0;
                end
            end

            default: state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q       <= LSU_IDLE;
            rnw_q         <= 1'b1;
            funct3_q      <= 3'b000;
            addr_q        <= '0;
            store_data_q  <= '0;
            retry_q       <= '0;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_rdata_q  <= '0;
            resp_err_q    <= 1'b0;
            resp_mis_q    <= 1'b0;
            enable_q      <= 1'b0;
            cache_rnw_q   <= 1'b1;
            cache_wdata_q <= '0;
        end else begin
            state_q       <= state_d;
            rnw_q         <= rnw_d;
            funct3_q      <= funct3_d;
            addr_q        <= addr_d;
            store_data_q  <= store_data_d;
            retry_q       <= retry_d;
            req_ready_q   <= req_ready_d;
            resp_valid_q  <= resp_valid_d;
            resp_rdata_q  <= resp_rdata_d;
            resp_err_q    <= resp_err_d;
            resp_mis_q    <= resp_mis_d;
            enable_q      <= enable_d;
            cache_rnw_q   <= cache_rnw_d;
            cache_wdata_q <= cache_wdata_d;
        end
    end

    assign o_req_ready       = req_ready_q;
    assign o_resp_valid      = resp_valid_q;
    assign o_resp_rdata      = resp_rdata_q;
    assign o_resp_err        = resp_err_q;
    assign o_resp_misaligned = resp_mis_q;
    assign o_enable          = enable_q;
    assign o_rnw             = cache_rnw_q;
    assign o_addr            = {addr_q[AWIDTH-1:2], 2'b00};
    assign o_wdata           = cache_wdata_q;

endmodule
